// File: rtl/accel_pkg.sv
// accel_pkg: shared FSM state type, default widths and beat-count helpers for the psum accumulator.
package accel_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  localparam int PSUM_W_DEF = 5;
  localparam int ACC_W_DEF = 16;
  function automatic int beat_count(input int mac_num, input int out_lanes);
    return mac_num / out_lanes;
  endfunction
  function automatic int cnt_width(input int beats);
    return beats > 1 ? $clog2(beats) : 1;
  endfunction
endpackage

// File: rtl/psum_acc_lane.sv
// psum_acc_lane: one lane accumulator with load/add/enable-zero and carry detect.
// Optional saturation on carry-out under PSUM_ACC_SATURATE_EN; wraps otherwise.
module psum_acc_lane
  import accel_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              first,
  input  logic              en,
  input  logic [PSUM_W-1:0] psum,
  output logic [ACC_W-1:0]  acc,
  output logic              carry
);
  logic [ACC_W:0] sum;
  logic [ACC_W-1:0] nxt;
  assign sum = {1'b0, acc} + (ACC_W+1)'(psum);
  assign carry = load & en & ~first & sum[ACC_W];
`ifdef PSUM_ACC_SATURATE_EN
  // once clamped, any further add carries again, so the lane stays at max
  assign nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign nxt = sum[ACC_W-1:0];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (load) acc <= !en ? '0 : first ? ACC_W'(psum) : nxt;
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates MAC psums across passes and drains them as a ready/valid stream.
// Saturating accumulation is selected with PSUM_ACC_SATURATE_EN.
module psum_accumulator
  import accel_pkg::*;
#(
  parameter int MAC_NUM = 256,
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_LANES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PSUM_W*MAC_NUM-1:0]  psum_in,
  input  logic [MAC_NUM-1:0]         lane_enable,
  input  logic                       psum_valid,
  input  logic                       psum_first,
  input  logic                       psum_last,
  output logic                       psum_ready,
  output logic [ACC_W*OUT_LANES-1:0] m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic                       busy,
  output logic                       overflow
);
  localparam int BEATS = beat_count(MAC_NUM, OUT_LANES);
  localparam int CNT_W = cnt_width(BEATS);
  localparam int BW = ACC_W * OUT_LANES;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W*MAC_NUM-1:0] acc_flat;
  logic [MAC_NUM-1:0] carry;
  logic xfer, first_eff;
  assign psum_ready = state != DRAIN;
  assign xfer = psum_valid & psum_ready;
  // any transfer seen while idle starts a new tile
  assign first_eff = psum_first | (state == IDLE);
  assign busy = state != IDLE;
  assign m_tvalid = state == DRAIN;
  assign m_tlast = m_tvalid & (cnt == CNT_W'(BEATS - 1));
  assign m_tdata = m_tvalid ? acc_flat[int'(cnt)*BW +: BW] : '0;
  for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
    psum_acc_lane #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (xfer),
      .first(first_eff),
      .en   (lane_enable[i]),
      .psum (psum_in[i*PSUM_W +: PSUM_W]),
      .acc  (acc_flat[i*ACC_W +: ACC_W]),
      .carry(carry[i])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      overflow <= 1'b0;
    end else if (xfer) begin
      state <= psum_last ? DRAIN : ACCUM;
      overflow <= !first_eff & (overflow | (|carry));
    end else if (m_tvalid & m_tready) begin
      cnt <= m_tlast ? '0 : cnt + CNT_W'(1);
      if (m_tlast) state <= IDLE;
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed self-checking bench for psum_accumulator (16 lanes, 4 per beat, 8-bit acc).
module tb_psum_accumulator;
  logic clk = 0, rst = 1;
  logic [79:0] psum_in = '0;
  logic [15:0] lane_enable = '1;
  logic psum_valid = 0, psum_first = 0, psum_last = 0, m_tready = 1;
  logic psum_ready, m_tvalid, m_tlast, busy, overflow;
  logic [31:0] m_tdata;
  logic [4:0] p_l [16];
  logic [7:0] exp_l [16];
  int n_chk = 0, n_pass = 0;

  psum_accumulator #(.MAC_NUM(16), .PSUM_W(5), .ACC_W(8), .OUT_LANES(4)) dut (
    .clk(clk), .rst(rst), .psum_in(psum_in), .lane_enable(lane_enable),
    .psum_valid(psum_valid), .psum_first(psum_first), .psum_last(psum_last),
    .psum_ready(psum_ready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send(input logic f, input logic l);
    for (int i = 0; i < 16; i++) psum_in[i*5 +: 5] = p_l[i];
    psum_first = f;
    psum_last = l;
    psum_valid = 1;
    @(negedge clk);
    psum_valid = 0;
  endtask

  task automatic drain(input string tag, input int nb);
    logic [31:0] e;
    m_tready = 1;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 4; j++) e[j*8 +: 8] = exp_l[b*4+j];
      check({tag, " valid"}, m_tvalid, 1);
      check({tag, " data"}, m_tdata, e);
      check({tag, " last"}, m_tlast, b == 3);
      check({tag, " ready_low"}, psum_ready, 0);
      @(negedge clk);
    end
    if (nb == 4) begin
      check({tag, " done_valid"}, m_tvalid, 0);
      check({tag, " done_ready"}, psum_ready, 1);
      check({tag, " done_busy"}, busy, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prev, e;
    logic pv, pr;
    logic [1:0] pat [4];
    int hs, stab;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    repeat (2) @(negedge clk);
    check("rst_valid", m_tvalid, 0);
    check("rst_last", m_tlast, 0);
    check("rst_data", m_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    rst = 0;
    @(negedge clk);
    check("rst_ready", psum_ready, 1);

    // single pass, all lanes 3
    for (int i = 0; i < 16; i++) begin p_l[i] = 3; exp_l[i] = 3; end
    send(1, 1);
    drain("single", 4);

    // three passes, lane i psum = i
    for (int i = 0; i < 16; i++) begin p_l[i] = 5'(i); exp_l[i] = 8'(3*i); end
    send(1, 0);
    check("acc_busy", busy, 1);
    check("acc_ready", psum_ready, 1);
    send(0, 0);
    send(0, 1);
    check("three_ovf", overflow, 0);
    drain("three", 4);

    // lane mask
    lane_enable = 16'h00FF;
    for (int i = 0; i < 16; i++) begin p_l[i] = 5'(i); exp_l[i] = i < 8 ? 8'(i) : 8'd0; end
    send(1, 1);
    lane_enable = '1;
    drain("mask", 4);

    // backpressure with psums offered during drain
    for (int i = 0; i < 16; i++) begin p_l[i] = 5'(i+1); exp_l[i] = 8'(i+1); end
    send(1, 1);
    psum_in = '1; psum_first = 1; psum_last = 1; psum_valid = 1;
    hs = 0; stab = 0; pv = 0; pr = 0; prev = '0;
    for (int c = 0; c < 40 && hs < 4; c++) begin
      m_tready = pat[c%4][0];
      if (pv && !pr && m_tdata != prev) stab++;
      if (m_tvalid && m_tready) begin
        for (int j = 0; j < 4; j++) e[j*8 +: 8] = exp_l[hs*4+j];
        check("bp data", m_tdata, e);
        check("bp last", m_tlast, hs == 3);
        hs++;
        if (m_tlast) psum_valid = 0;
      end
      pv = m_tvalid; pr = m_tready; prev = m_tdata;
      @(negedge clk);
    end
    psum_valid = 0;
    m_tready = 1;
    check("bp handshakes", hs, 4);
    check("bp stable", stab, 0);
    check("bp end_valid", m_tvalid, 0);
    check("bp end_ready", psum_ready, 1);

    // overflow on lane 0, then reset mid-drain
    for (int i = 0; i < 16; i++) begin p_l[i] = 0; exp_l[i] = 0; end
    p_l[0] = 31;
`ifdef PSUM_ACC_SATURATE_EN
    exp_l[0] = 8'd255;
`else
    exp_l[0] = 8'd23;
`endif
    send(1, 0);
    for (int k = 0; k < 7; k++) send(0, 0);
    check("ovf_before", overflow, 0);
    send(0, 1);
    check("ovf_set", overflow, 1);
    drain("ovf", 2);
    check("ovf_held", overflow, 1);
    rst = 1;
    #1;
    check("abort_valid", m_tvalid, 0);
    check("abort_last", m_tlast, 0);
    check("abort_ovf", overflow, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("abort_ready", psum_ready, 1);

    // overflow during ACCUM, then reload clears it and the tile drains from beat 0
    send(1, 0);
    for (int k = 0; k < 8; k++) send(0, 0);
    check("reload_ovf_set", overflow, 1);
    for (int i = 0; i < 16; i++) begin p_l[i] = 5'(i+2); exp_l[i] = 8'(i+2); end
    send(1, 1);
    check("reload_ovf_clr", overflow, 0);
    drain("post_rst", 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream stage of the MAC array.
- Captures the packed 5-bit partial sums from every MAC lane and accumulates them across input-channel passes into ACC_W-bit per-lane accumulators.
- After the last pass, drains the results as a ready/valid output stream, OUT_LANES lanes per beat, toward the ofmap write-back DMA.
- Backpressure on the input side tells the control unit when the MAC array may present the next tile's psums.

Parameters:
- MAC_NUM, 256, number of MAC lanes (must be a multiple of OUT_LANES).
- PSUM_W, 5, width of one MAC psum, unsigned.
- ACC_W, 16, accumulator width per lane, unsigned.
- OUT_LANES, 8, lanes packed per output beat.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- psum_in  in  PSUM_W*MAC_NUM  packed psums; lane i at bits [i*PSUM_W +: PSUM_W].
- lane_enable  in  MAC_NUM  per-lane enable, same mask the MAC array uses; sampled with psum_valid.
- psum_valid  in  1  psum_in is valid this cycle.
- psum_first  in  1  qualifies psum_valid: first pass of a tile; load instead of add.
- psum_last  in  1  qualifies psum_valid: final pass; drain after this.
- psum_ready  out  1  block accepts psums; transfer = psum_valid & psum_ready.
- m_tdata  out  ACC_W*OUT_LANES  output beat; beat b, slot j holds lane b*OUT_LANES+j at bits [j*ACC_W +: ACC_W].
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream accepts the beat.
- m_tlast  out  1  high on the final beat of a tile.
- busy  out  1  high in ACCUM or DRAIN.
- overflow  out  1  sticky: some enabled lane exceeded 2^ACC_W-1 during the current tile.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all accumulators=0; beat counter=0; m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, overflow=0. psum_ready=1 after reset release.
- FSM states: IDLE, ACCUM, DRAIN.
  - IDLE -> ACCUM on a transfer with psum_first=1 and psum_last=0.
  - IDLE -> DRAIN on a transfer with psum_first=1 and psum_last=1 (single-pass tile).
  - IDLE: a transfer with psum_first=0 is treated as first (load).
  - ACCUM -> DRAIN on a transfer with psum_last=1.
  - ACCUM: a transfer with psum_first=1 reloads (restarts the tile) and clears overflow.
  - DRAIN -> IDLE on the handshake of the beat with m_tlast=1.
- psum_ready = (state != DRAIN). Combinational from state only, never from psum_valid.
- Per transfer, for each lane i:
  - lane_enable[i]=0: acc[i] is forced to 0.
  - first: acc[i] = zero-extended psum.
  - otherwise: acc[i] = acc[i] + psum, with ACC_W+1-bit intermediate.
  - Overflow: carry-out sets overflow; the stored value follows the Optional Feature.
- Accumulator update latency: 1 cycle. The first output beat is valid the cycle after the transfer carrying psum_last.
- DRAIN:
  - Beat counter runs 0..MAC_NUM/OUT_LANES-1.
  - m_tdata is driven from registered accumulators, muxed by the counter.
  - m_tvalid=1 throughout DRAIN.
  - Counter advances only on m_tvalid & m_tready.
  - m_tdata and m_tlast are held stable while m_tready=0.
  - m_tlast = (counter == MAC_NUM/OUT_LANES-1).
  - Last handshake: counter resets to 0, m_tvalid drops the next cycle, and psum_ready rises that same cycle.
- overflow clears on the next first transfer; it is held through DRAIN for software readback.
- rst asserted mid-DRAIN: the stream aborts immediately. m_tvalid goes low asynchronously; no m_tlast is emitted.

Optional Feature:
- Macro PSUM_ACC_SATURATE_EN.
- Defined: on overflow, acc[i] clamps to 2^ACC_W-1 and stays clamped for further adds in that tile.
- Undefined: acc[i] wraps modulo 2^ACC_W.
- overflow flag behaviour is identical in both builds.

Decomposition:
- Shared package accel_pkg:
  - FSM state enum (IDLE/ACCUM/DRAIN).
  - Default PSUM_W and ACC_W constants.
  - Localparam helper for the beat count MAC_NUM/OUT_LANES and its counter width (clog2).
- One sub-module: psum_acc_lane. One lane's accumulator register with load/add/enable-zero, carry detect and the saturate option, instantiated MAC_NUM times in a generate loop.
- FSM, beat counter and output mux stay in the top.

Test Plan:
- Bench config MAC_NUM=16, OUT_LANES=4, PSUM_W=5, ACC_W=8.
- Single pass: all lanes psum=5'd3, first=last=1, m_tready=1 -> 4 beats of 0x03030303, m_tlast on beat 3, psum_ready low for exactly 4 cycles.
- Three passes with lane i psum=i, i.e. first, mid, last -> beat 0 = {6,3,0} packed as lanes 0..3 = 0,3,6,9; beat 3 lanes 12..15 = 36,39,42,45; overflow=0.
- Lane mask: lane_enable=16'h00FF -> lanes 8..15 output 0 on beats 2..3; lanes 0..7 correct.
- Backpressure: m_tready toggles 1,0,0,1 -> each beat's m_tdata held stable while stalled; exactly 4 handshakes; psum_valid during DRAIN is not accepted.
- Overflow: lane 0 psum=31 for 9 passes -> overflow=1. Lane 0 = 255 with PSUM_ACC_SATURATE_EN, 279 mod 256 = 23 without.
- Reset mid-DRAIN after beat 1 -> m_tvalid=0 immediately, overflow=0, psum_ready=1 after release, and the next tile drains normally from beat 0.
